// File: rtl/fetch_mem_arbiter_pkg.sv
// Shared encodings for the fetch/LSU memory-port arbiter: FSM states and
// transaction owner.
package fetch_mem_arbiter_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_REQ  = REQ,
        ST_RESP = RESP
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/fetch_mem_arbiter_prio.sv
// Priority select between LSU and IFU with a saturating starvation counter
// that forces an IFU win after StarveLimit consecutive LSU wins over it.
module fetch_arb_prio #(
    parameter int StarveLimit = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en_i,
    input  logic ifu_req_i,
    input  logic jumpFlag_i,
    input  logic lsu_req_i,
    output logic grant_lsu_o,
    output logic grant_ifu_o
);

    localparam int CntW = $clog2(StarveLimit + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(StarveLimit);

    logic [CntW-1:0] starve_cnt_q;
    logic [CntW-1:0] starve_cnt_d;
    logic            ifu_eligible;
    logic            ifu_starved;

    always_comb begin
        // A fetch being flushed this cycle is not a candidate for the port.
        ifu_eligible = ifu_req_i && !jumpFlag_i;
        ifu_starved  = ifu_eligible && (starve_cnt_q == CntMax);
        grant_lsu_o  = lsu_req_i && !ifu_starved;
        grant_ifu_o  = !grant_lsu_o && ifu_eligible;

        starve_cnt_d = starve_cnt_q;
        if (arb_en_i) begin
            if (grant_lsu_o && ifu_req_i && (starve_cnt_q != CntMax)) begin
                starve_cnt_d = starve_cnt_q + CntW'(1);
            end else if (grant_ifu_o) begin
                starve_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/fetch_mem_arbiter.sv
// Shares one memory port between the fetch unit and the LSU, one transaction
// in flight; fetch responses are discarded when a jump flush hits them.
module fetch_mem_arbiter
    import fetch_mem_arbiter_pkg::*;
#(
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 32,
    parameter int StarveLimit = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ifu_req_i,
    input  logic [AddrWidth-1:0]   ifu_addr_i,
    input  logic                   jumpFlag_i,
    output logic                   ifu_dataOk_o,
    output logic [DataWidth-1:0]   ifu_data_o,
    input  logic                   lsu_req_i,
    input  logic                   lsu_we_i,
    input  logic [AddrWidth-1:0]   lsu_addr_i,
    input  logic [DataWidth-1:0]   lsu_wdata_i,
    input  logic [DataWidth/8-1:0] lsu_wstrb_i,
    output logic                   lsu_dataOk_o,
    output logic [DataWidth-1:0]   lsu_data_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [DataWidth/8-1:0] mem_wstrb_o,
    input  logic                   mem_ack_i,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i
);

    localparam int StrbWidth = DataWidth / 8;

    arb_state_e             state_q;
    arb_owner_e             owner_q;
    logic                   drop_q;
    logic                   mem_req_q;
    logic                   mem_we_q;
    logic [AddrWidth-1:0]   mem_addr_q;
    logic [DataWidth-1:0]   mem_wdata_q;
    logic [StrbWidth-1:0]   mem_wstrb_q;
    logic                   ifu_ok_q;
    logic [DataWidth-1:0]   ifu_data_q;
    logic                   lsu_ok_q;
    logic [DataWidth-1:0]   lsu_data_q;
    logic                   grant_lsu;
    logic                   grant_ifu;
    logic                   ifu_flush;

    fetch_arb_prio #(
        .StarveLimit(StarveLimit)
    ) u_prio (
        .clk        (clk),
        .reset      (reset),
        .arb_en_i   (state_q == ST_IDLE),
        .ifu_req_i  (ifu_req_i),
        .jumpFlag_i (jumpFlag_i),
        .lsu_req_i  (lsu_req_i),
        .grant_lsu_o(grant_lsu),
        .grant_ifu_o(grant_ifu)
    );

    assign ifu_flush = (owner_q == OWN_IFU) && jumpFlag_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IFU;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            ifu_ok_q    <= 1'b0;
            ifu_data_q  <= '0;
            lsu_ok_q    <= 1'b0;
            lsu_data_q  <= '0;
        end else begin
            ifu_ok_q <= 1'b0;
            lsu_ok_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_lsu) begin
                        owner_q     <= OWN_LSU;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= lsu_we_i;
                        mem_addr_q  <= lsu_addr_i;
                        mem_wdata_q <= lsu_wdata_i;
                        mem_wstrb_q <= lsu_wstrb_i;
                        drop_q      <= 1'b0;
                        state_q     <= ST_REQ;
                    end else if (grant_ifu) begin
                        owner_q     <= OWN_IFU;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= ifu_addr_i;
                        mem_wdata_q <= '0;
                        mem_wstrb_q <= '1;
                        drop_q      <= 1'b0;
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // The address phase cannot be withdrawn; a flush only marks the reply.
                    if (ifu_flush) begin
                        drop_q <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_rvalid_i) begin
                        if (owner_q == OWN_LSU) begin
                            lsu_ok_q   <= 1'b1;
                            lsu_data_q <= mem_rdata_i;
                        end else if (!drop_q && !jumpFlag_i) begin
                            ifu_ok_q   <= 1'b1;
                            ifu_data_q <= mem_rdata_i;
                        end
                        drop_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (ifu_flush) begin
                        drop_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_wstrb_o  = mem_wstrb_q;
    assign ifu_dataOk_o = ifu_ok_q;
    assign ifu_data_o   = ifu_data_q;
    assign lsu_dataOk_o = lsu_ok_q;
    assign lsu_data_o   = lsu_data_q;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: directed scenarios plus randomized requester and
// bus traffic, checked every cycle against a bus-transaction reference model.
module tb_fetch_mem_arbiter;

  localparam int STARVE  = 4;
  localparam int PH_IDLE = 0;
  localparam int PH_ADDR = 1;
  localparam int PH_RESP = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_req_i;
  logic [31:0] ifu_addr_i;
  logic        jumpFlag_i;
  logic        ifu_dataOk_o;
  logic [31:0] ifu_data_o;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic [3:0]  lsu_wstrb_i;
  logic        lsu_dataOk_o;
  logic [31:0] lsu_data_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ack_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  // clock / reset
  always #5 clk = ~clk;

  fetch_mem_arbiter #(
    .AddrWidth(32),
    .DataWidth(32),
    .StarveLimit(STARVE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ifu_req_i(ifu_req_i),
    .ifu_addr_i(ifu_addr_i),
    .jumpFlag_i(jumpFlag_i),
    .ifu_dataOk_o(ifu_dataOk_o),
    .ifu_data_o(ifu_data_o),
    .lsu_req_i(lsu_req_i),
    .lsu_we_i(lsu_we_i),
    .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i),
    .lsu_wstrb_i(lsu_wstrb_i),
    .lsu_dataOk_o(lsu_dataOk_o),
    .lsu_data_o(lsu_data_o),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o),
    .mem_ack_i(mem_ack_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  int checks = 0;
  int errors = 0;

  // reference model: which bus phase the port is in and who owns it
  int          m_phase;
  int          m_starve;
  bit          m_lsu;
  bit          m_drop;
  bit          m_rst;
  logic        exp_req;
  logic        exp_we;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_wstrb;
  logic [31:0] exp_ifu_data;
  logic [31:0] exp_lsu_data;
  logic [31:0] ifu_exp_q[$];
  logic [31:0] lsu_exp_q[$];
  bit          grant_log[$];
  int          lsu_pulses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ifu_req_i    = 1'b0;
    ifu_addr_i   = '0;
    jumpFlag_i   = 1'b0;
    lsu_req_i    = 1'b0;
    lsu_we_i     = 1'b0;
    lsu_addr_i   = '0;
    lsu_wdata_i  = '0;
    lsu_wstrb_i  = '0;
    mem_ack_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  // Apply the inputs currently driven for one clock: advance the model, then
  // compare the DUT outputs on the following falling edge.
  task automatic tick();
    bit new_txn;
    bit ifu_elig;
    bit exp_ok;
    new_txn = 1'b0;
    m_rst   = 1'b0;
    if (reset) begin
      m_rst = 1'b1; m_phase = PH_IDLE; m_starve = 0; m_drop = 1'b0; m_lsu = 1'b0;
      exp_req = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
      exp_ifu_data = '0; exp_lsu_data = '0;
      ifu_exp_q.delete(); lsu_exp_q.delete();
    end else begin
      case (m_phase)
        PH_IDLE: begin
          ifu_elig = ifu_req_i && !jumpFlag_i;
          if (lsu_req_i && !(ifu_elig && m_starve == STARVE)) begin
            new_txn = 1'b1; m_lsu = 1'b1;
            exp_we = lsu_we_i; exp_addr = lsu_addr_i; exp_wdata = lsu_wdata_i; exp_wstrb = lsu_wstrb_i;
            if (ifu_req_i && m_starve < STARVE) m_starve++;
          end else if (ifu_elig) begin
            new_txn = 1'b1; m_lsu = 1'b0;
            exp_we = 1'b0; exp_addr = ifu_addr_i; exp_wstrb = 4'hF;
            m_starve = 0;
          end
          if (new_txn) begin
            m_phase = PH_ADDR; exp_req = 1'b1; m_drop = 1'b0;
          end
        end
        PH_ADDR: begin
          if (!m_lsu && jumpFlag_i) m_drop = 1'b1;
          if (mem_ack_i) begin
            m_phase = PH_RESP; exp_req = 1'b0;
          end
        end
        default: begin
          if (mem_rvalid_i) begin
            if (m_lsu) lsu_exp_q.push_back(mem_rdata_i);
            else if (!m_drop && !jumpFlag_i) ifu_exp_q.push_back(mem_rdata_i);
            m_phase = PH_IDLE; m_drop = 1'b0;
          end else if (!m_lsu && jumpFlag_i) begin
            m_drop = 1'b1;
          end
        end
      endcase
    end

    @(negedge clk);
    check("mem_req", mem_req_o, exp_req);
    if (exp_req || m_rst) begin
      check("mem_addr", mem_addr_o, exp_addr);
      check("mem_we", mem_we_o, exp_we);
      check("mem_wstrb", mem_wstrb_o, exp_wstrb);
      if (exp_we || m_rst) check("mem_wdata", mem_wdata_o, exp_wdata);
    end
    exp_ok = (ifu_exp_q.size() > 0);
    if (exp_ok) exp_ifu_data = ifu_exp_q.pop_front();
    check("ifu_dataOk", ifu_dataOk_o, exp_ok);
    check("ifu_data", ifu_data_o, exp_ifu_data);
    exp_ok = (lsu_exp_q.size() > 0);
    if (exp_ok) exp_lsu_data = lsu_exp_q.pop_front();
    check("lsu_dataOk", lsu_dataOk_o, exp_ok);
    check("lsu_data", lsu_data_o, exp_lsu_data);
    if (lsu_dataOk_o === 1'b1) lsu_pulses++;
    if (new_txn) grant_log.push_back(mem_addr_o[31]);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Random requesters (hold until dataOk) and a random-latency memory.
  task automatic run_random(input int ncyc, input int ifu_pct, input int lsu_pct,
                            input int jump_pct, input int ack_max, input int rv_max);
    int ack_wait;
    int rv_wait;
    int prev;
    ack_wait = 0;
    rv_wait  = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (ifu_dataOk_o === 1'b1) ifu_req_i = 1'b0;
      if (lsu_dataOk_o === 1'b1) lsu_req_i = 1'b0;
      if (!ifu_req_i && $urandom_range(99) < ifu_pct) begin
        ifu_req_i  = 1'b1;
        ifu_addr_i = 32'h8000_0000 | ($urandom() & 32'h7FFF_FFFC);
      end
      jumpFlag_i = ($urandom_range(99) < jump_pct);
      if (jumpFlag_i) ifu_addr_i = 32'h8000_0000 | ($urandom() & 32'h7FFF_FFFC);
      if (!lsu_req_i && $urandom_range(99) < lsu_pct) begin
        lsu_req_i   = 1'b1;
        lsu_we_i    = 1'($urandom_range(1));
        lsu_addr_i  = $urandom() & 32'h7FFF_FFFC;
        lsu_wdata_i = $urandom();
        lsu_wstrb_i = 4'($urandom_range(15));
      end
      mem_ack_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom();
      case (m_phase)
        PH_ADDR: begin
          if (ack_wait == 0) mem_ack_i = 1'b1;
          else ack_wait--;
          mem_rvalid_i = ($urandom_range(9) == 0);
        end
        PH_RESP: begin
          if (rv_wait == 0) mem_rvalid_i = 1'b1;
          else rv_wait--;
          mem_ack_i = ($urandom_range(9) == 0);
        end
        default: begin
          mem_ack_i    = ($urandom_range(9) == 0);
          mem_rvalid_i = ($urandom_range(9) == 0);
        end
      endcase
      prev = m_phase;
      tick();
      if (prev != PH_ADDR && m_phase == PH_ADDR) ack_wait = $urandom_range(ack_max);
      if (prev != PH_RESP && m_phase == PH_RESP) rv_wait = $urandom_range(rv_max);
    end
  endtask

  bit t2_exp[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    reset = 1'b1;
    idle_inputs();
    lsu_pulses = 0;
    do_reset();

    // 1: single fetch, ack at once, rvalid two cycles after ack
    ifu_req_i = 1'b1; ifu_addr_i = 32'h8000_0000; tick();
    mem_ack_i = 1'b1; tick();
    mem_ack_i = 1'b0; tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0013; tick();
    ifu_req_i = 1'b0; mem_rvalid_i = 1'b0; tick();
    check("t1_ifu_data", ifu_data_o, 32'h0000_0013);

    // 3: flush during the response phase drops the fetch
    ifu_req_i = 1'b1; ifu_addr_i = 32'h8000_0100; tick();
    mem_ack_i = 1'b1; tick();
    mem_ack_i = 1'b0; jumpFlag_i = 1'b1; ifu_addr_i = 32'h8000_0200; tick();
    jumpFlag_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; tick();
    mem_rvalid_i = 1'b0;
    check("t3_ifu_kept", ifu_data_o, 32'h0000_0013);
    tick();
    check("t3_refetch_addr", mem_addr_o, 32'h8000_0200);
    mem_ack_i = 1'b1; tick();
    mem_ack_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0093; tick();
    ifu_req_i = 1'b0; mem_rvalid_i = 1'b0; tick();
    check("t3_ifu_data", ifu_data_o, 32'h0000_0093);

    // 4: store with a three-cycle ack delay
    lsu_pulses = 0;
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h1000_0040;
    lsu_wdata_i = 32'hA5A5_5A5A; lsu_wstrb_i = 4'b0011;
    tick(); tick(); tick();
    mem_ack_i = 1'b1; tick();
    check("t4_wstrb", mem_wstrb_o, 4'b0011);
    mem_ack_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0; tick();
    lsu_req_i = 1'b0; mem_rvalid_i = 1'b0; tick(); tick();
    check("t4_pulses", lsu_pulses, 1);

    // 5: flush coincides with rvalid; pending LSU load takes the next slot
    ifu_req_i = 1'b1; ifu_addr_i = 32'h8000_0300; tick();
    mem_ack_i = 1'b1; tick();
    mem_ack_i = 1'b0; lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h1000_0080; tick();
    jumpFlag_i = 1'b1; ifu_addr_i = 32'h8000_0400; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678; tick();
    jumpFlag_i = 1'b0; mem_rvalid_i = 1'b0;
    check("t5_dropped", ifu_data_o, 32'h0000_0093);
    tick();
    check("t5_lsu_wins", mem_addr_o, 32'h1000_0080);
    mem_ack_i = 1'b1; tick();
    mem_ack_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA; tick();
    lsu_req_i = 1'b0; mem_rvalid_i = 1'b0;
    check("t5_lsu_data", lsu_data_o, 32'h5555_AAAA);
    tick();
    mem_ack_i = 1'b1; tick();
    mem_ack_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0517; tick();
    ifu_req_i = 1'b0; mem_rvalid_i = 1'b0; tick();

    // 6: reset in the response phase, then a stale rvalid
    ifu_req_i = 1'b1; ifu_addr_i = 32'h8000_0500; tick();
    mem_ack_i = 1'b1; tick();
    mem_ack_i = 1'b0; reset = 1'b1; tick();
    reset = 1'b0; ifu_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF; tick();
    mem_rvalid_i = 1'b0; tick();
    check("t6_ifu_data", ifu_data_o, 32'h0);
    check("t6_lsu_data", lsu_data_o, 32'h0);

    // 2: both requesting continuously, observe grant order on the bus
    do_reset();
    grant_log.delete();
    run_random(31, 100, 100, 0, 0, 0);
    check("t2_ngrants", 32'(grant_log.size() >= 10), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i < grant_log.size()) check("t2_grant", 32'(grant_log[i]), 32'(t2_exp[i]));
    end

    // randomized traffic
    do_reset();
    run_random(1500, 60, 60, 8, 3, 3);
    do_reset();
    run_random(1000, 100, 100, 5, 0, 2);
    do_reset();
    run_random(800, 30, 80, 15, 2, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
